xc_sha3_lane_seq: RTL and testbench

XC_SHA3_LANE_SEQ -- requirements
Module: xc_sha3_lane_seq

---
 rtl/xc_sha3_pkg.sv | 30 +++
 rtl/xc_sha3_lane_seq_if.sv | 29 ++
 rtl/xc_sha3_lane_idx.sv | 37 +++
 rtl/xc_sha3_lane_seq.sv | 115 +++++++++++
 tb/tb_xc_sha3_lane_seq.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xc_sha3_pkg.sv
// Shared Keccak lane-sweep definitions: function encodings, lane count, FSM states.
// Used by the lane sequencer and by the execute-stage sha3 unit.
package xc_sha3_pkg;

    localparam int unsigned LANES     = 25;
    localparam logic [2:0]  COORD_MAX = 3'd4;

    typedef enum logic [2:0] {
        FUNC_XY = 3'd0,
        FUNC_X1 = 3'd1,
        FUNC_X2 = 3'd2,
        FUNC_X4 = 3'd3,
        FUNC_YX = 3'd4
    } sha3_func_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } lane_state_e;

    // Operands never exceed 20, so a compare ladder replaces a real divider.
    function automatic logic [4:0] mod5(input logic [4:0] v);
        if (v >= 5'd20) return v - 5'd20;
        if (v >= 5'd15) return v - 5'd15;
        if (v >= 5'd10) return v - 5'd10;
        if (v >= 5'd5)  return v - 5'd5;
        return v;
    endfunction

endpackage

// File: rtl/xc_sha3_lane_seq_if.sv
// Command and lane-beat handshake bundle of the lane sequencer.
// master = command issuer / beat consumer, slave = the sequencer itself.
interface xc_sha3_lane_seq_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_func;
    logic [1:0]  cmd_shamt;
    logic [31:0] cmd_base;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [2:0]  out_x;
    logic [2:0]  out_y;
    logic        out_last;
    logic        busy;

    modport master (
        output cmd_valid, cmd_func, cmd_shamt, cmd_base, abort, out_ready,
        input  cmd_ready, out_valid, out_addr, out_x, out_y, out_last, busy
    );

    modport slave (
        input  cmd_valid, cmd_func, cmd_shamt, cmd_base, abort, out_ready,
        output cmd_ready, out_valid, out_addr, out_x, out_y, out_last, busy
    );

endinterface

// File: rtl/xc_sha3_lane_idx.sv
// Keccak lane index for (x,y) under the selected permutation, shifted by shamt.
// Purely combinational, no handshake; illegal functions map to offset 0.
module xc_sha3_lane_idx
    import xc_sha3_pkg::*;
(
    input  logic [2:0]  i_x,
    input  logic [2:0]  i_y,
    input  logic [2:0]  i_func,
    input  logic [1:0]  i_shamt,
    output logic [31:0] o_offset
);

    logic [4:0] w_x;
    logic [4:0] w_y;
    logic [4:0] w_row;
    logic [4:0] w_idx;

    assign w_x   = {2'b00, i_x};
    assign w_y   = {2'b00, i_y};
    assign w_row = w_y * 5'd5;

    always_comb begin
        w_idx = '0;
        case (i_func)
            FUNC_XY: w_idx = w_x + w_row;
            FUNC_X1: w_idx = mod5(w_x + 5'd1) + w_row;
            FUNC_X2: w_idx = mod5(w_x + 5'd2) + w_row;
            FUNC_X4: w_idx = mod5(w_x + 5'd4) + w_row;
            // Rho-pi destination: new x = y, new y = (2x + 3y) mod 5.
            FUNC_YX: w_idx = w_y + mod5(w_x + w_x + w_y + w_y + w_y) * 5'd5;
            default: w_idx = '0;
        endcase
    end

    assign o_offset = {27'd0, w_idx} << i_shamt;

endmodule

// File: rtl/xc_sha3_lane_seq.sv
// Sweeps all 25 Keccak lanes, one address beat per out handshake; first beat 1 cycle after accept.
// Beats hold while out_ready is low; abort drops the sweep and blocks command accept that cycle.
module xc_sha3_lane_seq
    import xc_sha3_pkg::*;
#(
    parameter bit RESP_LAST = 1'b1
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    xc_sha3_lane_seq_if.slave    bus
);

    lane_state_e r_state;
    lane_state_e w_state_nxt;
    logic [2:0]  r_x;
    logic [2:0]  r_y;
    logic [2:0]  w_x_nxt;
    logic [2:0]  w_y_nxt;
    logic [2:0]  r_func;
    logic [2:0]  w_func_nxt;
    logic [1:0]  r_shamt;
    logic [1:0]  w_shamt_nxt;
    logic [31:0] r_base;
    logic [31:0] w_base_nxt;

    logic        w_cmd_rdy;
    logic        w_emit;
    logic        w_beat_hs;
    logic        w_at_last;
    logic [31:0] w_offset;

    assign w_emit    = (r_state == ST_EMIT);
    assign w_cmd_rdy = (r_state == ST_IDLE) && !bus.abort;
    assign w_beat_hs = w_emit && bus.out_ready;
    assign w_at_last = (r_x == COORD_MAX) && (r_y == COORD_MAX);

    xc_sha3_lane_idx u_idx (
        .i_x      (r_x),
        .i_y      (r_y),
        .i_func   (r_func),
        .i_shamt  (r_shamt),
        .o_offset (w_offset)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_func_nxt  = r_func;
        w_shamt_nxt = r_shamt;
        w_base_nxt  = r_base;

        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid && w_cmd_rdy) begin
                    w_state_nxt = ST_EMIT;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_func_nxt  = bus.cmd_func;
                    w_shamt_nxt = bus.cmd_shamt;
                    w_base_nxt  = bus.cmd_base;
                end
            end
            ST_EMIT: begin
                if (w_beat_hs) begin
                    if (w_at_last) begin
                        w_state_nxt = ST_IDLE;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                    end else if (r_x == COORD_MAX) begin
                        w_x_nxt = '0;
                        w_y_nxt = r_y + 3'd1;
                    end else begin
                        w_x_nxt = r_x + 3'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Abort wins over both the beat handshake and the command accept.
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_func  <= '0;
            r_shamt <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_func  <= w_func_nxt;
            r_shamt <= w_shamt_nxt;
            r_base  <= w_base_nxt;
        end
    end

    assign bus.cmd_ready = w_cmd_rdy;
    assign bus.out_valid = w_emit;
    assign bus.out_addr  = r_base + w_offset;
    assign bus.out_x     = r_x;
    assign bus.out_y     = r_y;
    assign bus.out_last  = RESP_LAST && w_emit && w_at_last;
    assign bus.busy      = w_emit;

endmodule

// File: tb/tb_xc_sha3_lane_seq.sv
// Bench for xc_sha3_lane_seq: scoreboard of expected beats per accepted command,
// a table of hand-computed lane addresses, and sequences for stall, abort and reset.
module tb_xc_sha3_lane_seq;
    import xc_sha3_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  x;
        logic [2:0]  y;
        logic        last;
    } beat_t;

    typedef struct {
        string       name;
        logic [2:0]  func;
        logic [1:0]  shamt;
        logic [31:0] base;
        int          x;
        int          y;
        logic [31:0] exp;
    } vec_t;

    logic g_clk    = 1'b0;
    logic g_resetn = 1'b0;

    xc_sha3_lane_seq_if bus();

    xc_sha3_lane_seq #(.RESP_LAST(1'b1)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus)
    );

    always #5 g_clk = ~g_clk;

    int          checks   = 0;
    int          failures = 0;
    int          beats    = 0;
    beat_t       sb_q[$];
    logic [31:0] beat_addr [25];
    logic        have_hold = 1'b0;
    beat_t       held;
    vec_t        vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_addr(input int func, input int shamt,
                                               input logic [31:0] base, input int x, input int y);
        int idx;
        case (func)
            0:       idx = x + 5 * y;
            1:       idx = (x + 1) % 5 + 5 * y;
            2:       idx = (x + 2) % 5 + 5 * y;
            3:       idx = (x + 4) % 5 + 5 * y;
            4:       idx = y + 5 * ((2 * x + 3 * y) % 5);
            default: idx = 0;
        endcase
        return base + (32'(idx) << shamt);
    endfunction

    // Monitor: runs on the falling edge, when outputs are settled and inputs stable.
    always @(negedge g_clk) begin
        if (!g_resetn) begin
            sb_q.delete();
            have_hold = 1'b0;
        end else begin
            if (have_hold) begin
                chk("stall_addr", bus.out_addr, held.addr);
                chk("stall_xy_last", 32'({bus.out_valid, bus.out_x, bus.out_y, bus.out_last}),
                    32'({1'b1, held.x, held.y, held.last}));
            end
            have_hold = bus.out_valid && !bus.out_ready && !bus.abort;
            if (have_hold) begin
                held.addr = bus.out_addr;
                held.x    = bus.out_x;
                held.y    = bus.out_y;
                held.last = bus.out_last;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=beat(x=%0d,y=%0d) expected=no beat at %0t",
                             bus.out_x, bus.out_y, $time);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    chk("beat_addr", bus.out_addr, e.addr);
                    chk("beat_xy", 32'({bus.out_x, bus.out_y}), 32'({e.x, e.y}));
                    chk("beat_last", 32'(bus.out_last), 32'(e.last));
                    beat_addr[int'(bus.out_x) + 5 * int'(bus.out_y)] = bus.out_addr;
                end
                beats++;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                for (int y = 0; y < 5; y++) begin
                    for (int x = 0; x < 5; x++) begin
                        beat_t b;
                        b.addr = model_addr(int'(bus.cmd_func), int'(bus.cmd_shamt), bus.cmd_base, x, y);
                        b.x    = 3'(x);
                        b.y    = 3'(y);
                        b.last = (x == 4) && (y == 4);
                        sb_q.push_back(b);
                    end
                end
            end
            if (bus.abort) sb_q.delete();
        end
    end

    // One command; pct = out_ready probability, abort_at = beat index to abort on (-1: none).
    task automatic run_sweep(input logic [2:0] func, input logic [1:0] shamt,
                             input logic [31:0] base, input int pct, input int abort_at);
        int n;
        n     = 0;
        beats = 0;
        @(posedge g_clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_func  = func;
        bus.cmd_shamt = shamt;
        bus.cmd_base  = base;
        bus.out_ready = 1'b0;
        @(negedge g_clk);
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        @(posedge g_clk); #1;
        bus.cmd_valid = 1'b0;
        chk("first_valid", 32'(bus.out_valid), 32'd1);
        chk("first_xy", 32'({bus.out_x, bus.out_y}), 32'd0);
        chk("busy_emit", 32'(bus.busy), 32'd1);
        chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
        while (n < 400) begin
            if (pct >= 100) bus.out_ready = 1'b1;
            else            bus.out_ready = ($urandom_range(0, 99) < pct);
            if (beats == abort_at) begin
                bus.abort     = 1'b1;
                bus.out_ready = 1'b1;
            end
            @(negedge g_clk); #1;
            if (beats >= LANES || bus.abort) break;
            @(posedge g_clk); #1;
            n++;
        end
        @(posedge g_clk); #1;
        chk("end_valid", 32'(bus.out_valid), 32'd0);
        chk("end_busy", 32'(bus.busy), 32'd0);
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("end_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("beat_count", 32'(beats), (abort_at >= 0) ? 32'(abort_at + 1) : 32'(LANES));
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{"xy_00",      FUNC_XY, 2'd3, 32'h0000_1000, 0, 0, 32'h0000_1000};
        vecs[1]  = '{"xy_10",      FUNC_XY, 2'd3, 32'h0000_1000, 1, 0, 32'h0000_1008};
        vecs[2]  = '{"xy_44",      FUNC_XY, 2'd3, 32'h0000_1000, 4, 4, 32'h0000_10C0};
        vecs[3]  = '{"yx_10",      FUNC_YX, 2'd0, 32'h0000_0000, 1, 0, 32'd10};
        vecs[4]  = '{"yx_11",      FUNC_YX, 2'd0, 32'h0000_0000, 1, 1, 32'd1};
        vecs[5]  = '{"yx_23",      FUNC_YX, 2'd0, 32'h0000_0000, 2, 3, 32'd18};
        vecs[6]  = '{"x1_40",      FUNC_X1, 2'd0, 32'h0000_0000, 4, 0, 32'd0};
        vecs[7]  = '{"x1_42",      FUNC_X1, 2'd0, 32'h0000_0000, 4, 2, 32'd10};
        vecs[8]  = '{"x4_40",      FUNC_X4, 2'd0, 32'h0000_0000, 4, 0, 32'd3};
        vecs[9]  = '{"wrap_00",    FUNC_XY, 2'd3, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8};
        vecs[10] = '{"wrap_10",    FUNC_XY, 2'd3, 32'hFFFF_FFF8, 1, 0, 32'h0000_0000};
        vecs[11] = '{"illegal_32", 3'd6,    2'd2, 32'h0000_2000, 3, 2, 32'h0000_2000};
        vecs[12] = '{"x2_31",      FUNC_X2, 2'd1, 32'h0000_0100, 3, 1, 32'h0000_010A};

        bus.cmd_valid = 1'b0;
        bus.cmd_func  = '0;
        bus.cmd_shamt = '0;
        bus.cmd_base  = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge g_clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_xy", 32'({bus.out_x, bus.out_y}), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        g_resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_sweep(vecs[i].func, vecs[i].shamt, vecs[i].base, 100, -1);
            chk(vecs[i].name, beat_addr[vecs[i].y * 5 + vecs[i].x], vecs[i].exp);
        end

        // Random backpressure: monitor checks hold-stability on every stalled cycle.
        run_sweep(FUNC_X2, 2'd1, 32'h0000_0300, 50, -1);
        run_sweep(FUNC_YX, 2'd2, 32'h0000_0040, 30, -1);

        // Abort coinciding with the handshake of beat 7, then a fresh sweep from (0,0).
        run_sweep(FUNC_XY, 2'd0, 32'h0000_0040, 100, 7);
        run_sweep(FUNC_X1, 2'd2, 32'h0000_0080, 100, -1);

        // Abort coinciding with a command offer in IDLE: the command must be refused.
        @(posedge g_clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_func  = FUNC_YX;
        bus.abort     = 1'b1;
        #1;
        chk("cmd_ready_abort", 32'(bus.cmd_ready), 32'd0);
        @(posedge g_clk); #1;
        chk("abort_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_idle_busy", 32'(bus.busy), 32'd0);
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;

        // Reset in the middle of a sweep.
        @(posedge g_clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_func  = FUNC_XY;
        bus.cmd_shamt = 2'd0;
        bus.cmd_base  = 32'h0000_0500;
        bus.out_ready = 1'b1;
        @(posedge g_clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (5) @(posedge g_clk);
        #1;
        g_resetn = 1'b0;
        @(posedge g_clk); #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_last", 32'(bus.out_last), 32'd0);
        chk("midrst_xy", 32'({bus.out_x, bus.out_y}), 32'd0);
        g_resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge g_clk); #1;
            chk("post_rst_no_beat", 32'(bus.out_valid), 32'd0);
        end
        chk("post_rst_sb_empty", 32'(sb_q.size()), 32'd0);
        bus.out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
